linebuf_port_arbiter: RTL
=========================

# linebuf_port_arbiter

Shares one single-port BRAM line buffer (`bram_buffer`) between two requesters: the AXI fill side, which writes pixel words, and the VGA scan-out side, which reads them. The block grants at most one access per cycle and drives the BRAM port. It also compensates for the BRAM's one-cycle read latency and its garbage output on non-read cycles by returning read data with a registered valid and a held data value. The display read side has priority, and a bounded-wait guard stops the fill side from being starved.

## Interface
Parameters:
- `BITS`, 32, data word width.
- `ADD_WIDTH`, 9, BRAM address width; depth is 2^`ADD_WIDTH`.
- `MAX_WAIT`, 4, maximum consecutive cycles a pending write may lose arbitration. Legal range is 1..255.

Ports:
- `clk` input, 1: clock; all state updates on its rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `wr_valid` input, 1: write request.
- `wr_ready` output, 1: write granted this cycle.
- `wr_addr` input, `ADD_WIDTH`: write address.
- `wr_data` input, `BITS`: write data.
- `rd_valid` input, 1: read request.
- `rd_ready` output, 1: read granted this cycle.
- `rd_addr` input, `ADD_WIDTH`: read address.
- `rd_rvalid` output, 1: read data returned this cycle.
- `rd_rdata` output, `BITS`: read data; held stable between returns.
- `bram_addr` output, `ADD_WIDTH`: BRAM address.
- `bram_cen` output, 1: BRAM chip enable.
- `bram_wen` output, 1: BRAM write enable.
- `bram_indata` output, `BITS`: BRAM write data.
- `bram_outdata` input, `BITS`: BRAM read data. It is valid only in the cycle after a read; otherwise it is undefined.

## Operation
- Handshake: a transfer occurs in any cycle where `*_valid & *_ready`. Each ready output is combinational from both valids and the wait state. A requester must hold valid, address and data stable until it sees ready.
- Arbitration per cycle:
  - Only `rd_valid`: read granted.
  - Only `wr_valid`: write granted.
  - Both valid: read granted, unless the guard fires (see Configuration).
  - Neither valid: no grant; `bram_cen`=0.
- Read grant: `bram_addr`=`rd_addr`, `bram_cen`=1, `bram_wen`=0.
- Write grant: `bram_addr`=`wr_addr`, `bram_indata`=`wr_data`, `bram_cen`=1, `bram_wen`=1.
- No grant: `bram_addr` and `bram_indata` are don't-care.
- `rd_ready` and `wr_ready` are never high together.
- Read return: `rd_rvalid` is a register set to 1 in the cycle after a read grant, and 0 otherwise.
  - When `rd_rvalid`=1, `rd_rdata`=`bram_outdata` (pass-through), and the same value is captured into a hold register.
  - When `rd_rvalid`=0, `rd_rdata`=hold register.
  - `bram_outdata` never reaches `rd_rdata` in any other cycle.
- Back-to-back reads: one per cycle, fully pipelined; each returns exactly one cycle after its grant.
- Write then read of the same address in consecutive cycles: the read returns the newly written data. No forwarding is needed, because the BRAM write commits at the edge before the read.
- Reset (asynchronous, takes effect immediately):
  - `rd_rvalid`=0, hold register=0, wait counter=0.
  - While `rst`=1: `wr_ready`=`rd_ready`=`bram_cen`=`bram_wen`=0.
  - A read granted in the cycle before reset asserts produces no `rd_rvalid`.

## Timing
- Grant-to-BRAM: combinational, same cycle T.
- Read latency: grant in T, `rd_rvalid` and data in T+1.
- Write latency: committed at the end of T; readable from a grant in T+1.
- Reset values:
  - `wr_ready`=0, `rd_ready`=0, `rd_rvalid`=0, `rd_rdata`=0.
  - `bram_cen`=0, `bram_wen`=0, `bram_addr`=0, `bram_indata`=0.
- Throughput: one access per cycle total.
- Worst-case write wait:
  - Guard compiled in: `MAX_WAIT` cycles.
  - Guard compiled out: unbounded.

## Configuration
- `LINEBUF_ANTISTARVE_EN` defined (guard compiled in):
  - An 8-bit wait counter increments each cycle `wr_valid`=1 and `wr_ready`=0.
  - The counter clears on a write grant or when `wr_valid`=0.
  - When both valids are high and the counter equals `MAX_WAIT`, the write is granted and the read stalls that one cycle.
  - The counter never exceeds `MAX_WAIT`.
- `LINEBUF_ANTISTARVE_EN` undefined: the counter is absent and reads always win when both sides request.

## Test plan
- Reset mid-read: grant a read at `addr` 3, assert `rst` in the next cycle → `rd_rvalid`=0 immediately, `rd_rdata`=0, `bram_cen`=0 while reset is held.
- Write/readback: write `0xDEADBEEF` to `addr` 5, read `addr` 5 in the next cycle → `rd_rvalid`=1 exactly one cycle after the read grant, with `rd_rdata`=`0xDEADBEEF`.
- Data hold: after the readback above, leave the port idle and randomise `bram_outdata` for 10 cycles → `rd_rdata` stays `0xDEADBEEF` and `rd_rvalid`=0.
- Pipelined reads: after preloading addresses 0..7, read them on 8 consecutive cycles → 8 consecutive `rd_rvalid` pulses returning the preloaded words in order.
- Contention, guard in: with `MAX_WAIT`=4, hold `rd_valid` and `wr_valid` high continuously → 4 read grants then 1 write grant, repeating; `wr_ready` is never high with `rd_ready`.
- Contention, guard out: same stimulus for 50 cycles → 50 read grants, `wr_ready`=0 throughout; the write is granted in the first cycle `rd_valid` drops.

Source files
------------

// File: rtl/linebuf_port_arbiter.sv
// Single-port BRAM line buffer arbiter: display reads win, fill writes take the rest.
// Define LINEBUF_ANTISTARVE_EN to compile in the bounded-wait guard for the write side.
module linebuf_port_arbiter #(
  parameter int BITS      = 32,
  parameter int ADD_WIDTH = 9,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADD_WIDTH-1:0] wr_addr,
  input  logic [BITS-1:0]      wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [ADD_WIDTH-1:0] rd_addr,
  output logic                 rd_rvalid,
  output logic [BITS-1:0]      rd_rdata,
  output logic [ADD_WIDTH-1:0] bram_addr,
  output logic                 bram_cen,
  output logic                 bram_wen,
  output logic [BITS-1:0]      bram_indata,
  input  logic [BITS-1:0]      bram_outdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("linebuf_port_arbiter: MAX_WAIT must be in 1..255");
  end

  logic            rd_rvalid_q;
  logic [BITS-1:0] hold_q;
  logic [BITS-1:0] hold_d;
  logic            guard_fire;

`ifdef LINEBUF_ANTISTARVE_EN
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;

  assign guard_fire = wr_valid && rd_valid && (wait_cnt_q == 8'(MAX_WAIT));

  // Counts consecutive lost cycles of a pending write; saturates at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!wr_valid || wr_ready) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < 8'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  always_comb begin
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    if (!rst) begin
      if (rd_valid && !guard_fire) begin
        rd_ready = 1'b1;
      end else if (wr_valid) begin
        wr_ready = 1'b1;
      end
    end
  end

  // Idle port drives zeros so reset values and idle cycles are deterministic.
  always_comb begin
    bram_addr   = '0;
    bram_indata = '0;
    if (wr_ready) begin
      bram_addr   = wr_addr;
      bram_indata = wr_data;
    end else if (rd_ready) begin
      bram_addr   = rd_addr;
    end
  end

  assign bram_cen = rd_ready | wr_ready;
  assign bram_wen = wr_ready;

  // BRAM output is only trusted in the return cycle; otherwise replay the last return.
  assign hold_d    = rd_rvalid_q ? bram_outdata : hold_q;
  assign rd_rdata  = hold_d;
  assign rd_rvalid = rd_rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rvalid_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      rd_rvalid_q <= rd_ready;
      hold_q      <= hold_d;
    end
  end

endmodule
